// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_EXC  = 3'd4
    } redir_src_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Branch immediate is a word offset: sign-extend, then scale to bytes.
    function automatic logic [31:0] br_byte_offset(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch request bus between the PC sequencer (master) and instruction memory (slave).
interface pc_fetch_sequencer_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;

    modport master (output fetch_valid, output fetch_pc, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_fetch_sequencer_target_mux.sv
// Redirect target computation and priority selection (exc > jr > j > br).
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_offset,
    input  logic        j_valid,
    input  logic [31:0] j_pc4,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        exc_valid,
    output logic        redir_valid,
    output logic [31:0] redir_target,
    output logic        misalign
);

    redir_src_e src;
    logic       jr_misaligned;

    assign jr_misaligned = (jr_target[1:0] != 2'b00);

    always_comb begin
        src = SRC_NONE;
        if (exc_valid)     src = SRC_EXC;
        else if (jr_valid) src = SRC_JR;
        else if (j_valid)  src = SRC_J;
        else if (br_taken) src = SRC_BR;
    end

    always_comb begin
        redir_valid  = (src != SRC_NONE);
        redir_target = '0;
        misalign     = 1'b0;
        case (src)
            SRC_BR:  redir_target = br_pc4 + br_byte_offset(br_offset);
            SRC_J:   redir_target = {j_pc4[31:28], j_index, 2'b00};
            SRC_JR: begin
                // A misaligned register target is turned into an exception redirect.
                if (jr_misaligned) begin
                    redir_target = EXC_VECTOR;
                    misalign     = 1'b1;
                end else begin
                    redir_target = jr_target;
                end
            end
            SRC_EXC: redir_target = EXC_VECTOR;
            default: redir_target = '0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: FSM, PC register, pending-redirect register and redirect counter.
//   state   | meaning
//   BOOT    | one idle cycle after reset, redirects ignored
//   RUN     | request outstanding on the fetch bus
//   HOLD    | stalled, no request; redirects load fetch_pc directly
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.master fetch_if,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [31:0]          br_pc4,
    input  logic [15:0]          br_offset,
    input  logic                 j_valid,
    input  logic [31:0]          j_pc4,
    input  logic [25:0]          j_index,
    input  logic                 jr_valid,
    input  logic [31:0]          jr_target,
    input  logic                 exc_valid,
    output logic                 redirect_taken,
    output logic                 misalign_err,
    output logic [CNT_W-1:0]     redirect_count
);

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [31:0]        pend_target_q, pend_target_d;
    logic               redirect_taken_q, redirect_taken_d;
    logic [CNT_W-1:0]   redirect_count_q, redirect_count_d;

    logic               redir_valid;
    logic [31:0]        redir_target;
    logic               redir_misalign;
    logic               accept;

    pc_target_mux #(.EXC_VECTOR(EXC_VECTOR)) u_target_mux (
        .br_taken     (br_taken),
        .br_pc4       (br_pc4),
        .br_offset    (br_offset),
        .j_valid      (j_valid),
        .j_pc4        (j_pc4),
        .j_index      (j_index),
        .jr_valid     (jr_valid),
        .jr_target    (jr_target),
        .exc_valid    (exc_valid),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .misalign     (redir_misalign)
    );

    assign fetch_if.fetch_valid = (state_q == ST_RUN);
    assign fetch_if.fetch_pc    = fetch_pc_q;
    assign accept               = fetch_if.fetch_valid & fetch_if.fetch_ready;

    assign redirect_taken = redirect_taken_q;
    assign redirect_count = redirect_count_q;
    // Redirects are ignored in BOOT, so a misaligned JR there is not reported.
    assign misalign_err   = rst_n & (state_q != ST_BOOT) & redir_misalign;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        pend_valid_d     = pend_valid_q;
        pend_target_d    = pend_target_q;
        redirect_taken_d = 1'b0;
        redirect_count_d = redirect_count_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    if (redir_valid) begin
                        fetch_pc_d       = redir_target;
                        pend_valid_d     = 1'b0;
                        redirect_taken_d = 1'b1;
                    end else if (pend_valid_q) begin
                        fetch_pc_d       = pend_target_q;
                        pend_valid_d     = 1'b0;
                        redirect_taken_d = 1'b1;
                    end else begin
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end
                    state_d = stall ? ST_HOLD : ST_RUN;
                end else if (redir_valid) begin
                    // Request still on the bus: PC must stay stable, park the redirect.
                    pend_valid_d  = 1'b1;
                    pend_target_d = redir_target;
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    fetch_pc_d       = redir_target;
                    pend_valid_d     = 1'b0;
                    redirect_taken_d = 1'b1;
                end else if (pend_valid_q) begin
                    fetch_pc_d       = pend_target_q;
                    pend_valid_d     = 1'b0;
                    redirect_taken_d = 1'b1;
                end
                state_d = stall ? ST_HOLD : ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase

        if (redirect_taken_d && (redirect_count_q != {CNT_W{1'b1}})) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_BOOT;
            fetch_pc_q       <= RESET_PC;
            pend_valid_q     <= 1'b0;
            pend_target_q    <= '0;
            redirect_taken_q <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            pend_valid_q     <= pend_valid_d;
            pend_target_q    <= pend_target_d;
            redirect_taken_q <= redirect_taken_d;
            redirect_count_q <= redirect_count_d;
        end
    end

endmodule
